// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller signal bundle
// Purpose: groups the hazard-detection inputs and pipeline-control outputs.
// Ports (via modports):
//   slave  (controller): inputs id_rs1/id_rs2/id_uses_rs1/id_uses_rs2/ex_rd/
//          ex_mem_read/ex_redirect/mem_req/mem_ready; outputs pc_enable,
//          if_id_enable, id_ex_enable, ex_mem_enable, if_id_flush, id_ex_flush,
//          mem_wb_bubble, mem_timeout, stall_count, flush_count, state.
//   master (pipeline side): the mirror image.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_redirect;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_enable;
  logic             if_id_enable;
  logic             id_ex_enable;
  logic             ex_mem_enable;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_bubble;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic             state;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_redirect, mem_req, mem_ready,
    input  pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, if_id_flush,
           id_ex_flush, mem_wb_bubble, mem_timeout, stall_count, flush_count,
           state
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_redirect, mem_req, mem_ready,
    output pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, if_id_flush,
           id_ex_flush, mem_wb_bubble, mem_timeout, stall_count, flush_count,
           state
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline hazard and sequencing controller
// Purpose: drives enables/flushes of the PC, IF/ID, ID/EX, EX/MEM registers and
// a MEM/WB bubble, resolving memory waits, EX-stage redirects and load-use
// hazards; keeps saturating stall/flush counters and a sticky timeout flag.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high
//   hz    - pipeline_hazard_ctrl_if.slave (hazard inputs, control outputs,
//           debug counters, state)
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  pipeline_hazard_ctrl_if.slave   hz
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  logic memstall;
  logic loaduse;
  logic sel_redirect;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic if_id_fl, id_ex_fl, bubble;

  assign memstall = hz.mem_req & ~hz.mem_ready;

  // Writes to x0 are discarded, so a load targeting x0 never creates a hazard.
  assign loaduse = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                   ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                    (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

  // Control outputs: same priority in RUN and MEM_WAIT, so the release cycle
  // of a memory wait naturally falls through to redirect/load-use/normal.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_fl     = 1'b0;
    id_ex_fl     = 1'b0;
    bubble       = 1'b0;
    sel_redirect = 1'b0;
    if (reset) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
    end else if (memstall) begin
      // Whole pipeline frozen; a pending redirect stays visible in EX.
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      bubble    = 1'b1;
    end else if (hz.ex_redirect) begin
      // Squashing ID makes any concurrent load-use hazard irrelevant.
      if_id_fl     = 1'b1;
      id_ex_fl     = 1'b1;
      sel_redirect = 1'b1;
    end else if (loaduse) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      id_ex_fl = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (memstall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (memstall) begin
          if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      // Debug only: the wait continues after the flag is raised.
      if ((state_q == MEM_WAIT) && (wait_cnt_q == WAIT_MAX)) begin
        mem_timeout_q <= 1'b1;
      end
      if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (sel_redirect && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign hz.pc_enable     = pc_en;
  assign hz.if_id_enable  = if_id_en;
  assign hz.id_ex_enable  = id_ex_en;
  assign hz.ex_mem_enable = ex_mem_en;
  assign hz.if_id_flush   = if_id_fl;
  assign hz.id_ex_flush   = id_ex_fl;
  assign hz.mem_wb_bubble = bubble;
  assign hz.mem_timeout   = mem_timeout_q;
  assign hz.stall_count   = stall_cnt_q;
  assign hz.flush_count   = flush_cnt_q;
  assign hz.state         = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, bubble}
  localparam logic [6:0] C_ZERO  = 7'b0000_00_0;
  localparam logic [6:0] C_NORM  = 7'b1111_00_0;
  localparam logic [6:0] C_MEM   = 7'b0000_00_1;
  localparam logic [6:0] C_REDIR = 7'b1111_11_0;
  localparam logic [6:0] C_LU    = 7'b0011_01_0;

  typedef struct {
    string            tag;
    logic [6:0]       ctrl;
    logic             st;
    logic             to;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ctrl_obs();
    return {hz.pc_enable, hz.if_id_enable, hz.id_ex_enable, hz.ex_mem_enable,
            hz.if_id_flush, hz.id_ex_flush, hz.mem_wb_bubble};
  endfunction

  task automatic set_in(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic mr,
                        input logic redir, input logic req, input logic rdy);
    hz.id_rs1      = rs1;
    hz.id_uses_rs1 = u1;
    hz.id_rs2      = rs2;
    hz.id_uses_rs2 = u2;
    hz.ex_rd       = rd;
    hz.ex_mem_read = mr;
    hz.ex_redirect = redir;
    hz.mem_req     = req;
    hz.mem_ready   = rdy;
  endtask

  // Pushes the expectation for the cycle just driven, then moves to the next
  // drive point (2 time units after the following rising edge).
  task automatic push(input string tag, input logic [6:0] ctrl, input logic st,
                      input logic to, input logic [CNT_W-1:0] stall,
                      input logic [CNT_W-1:0] flush);
    exp_t e;
    e.tag = tag; e.ctrl = ctrl; e.st = st; e.to = to; e.stall = stall; e.flush = flush;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: combinational outputs checked mid-cycle, registered state after
  // the edge that closes the cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.tag, ".ctrl"}, 32'(ctrl_obs()), 32'(e.ctrl));
        @(posedge clk);
        #1;
        chk({e.tag, ".state"}, 32'(hz.state), 32'(e.st));
        chk({e.tag, ".timeout"}, 32'(hz.mem_timeout), 32'(e.to));
        chk({e.tag, ".stall_count"}, 32'(hz.stall_count), 32'(e.stall));
        chk({e.tag, ".flush_count"}, 32'(hz.flush_count), 32'(e.flush));
      end
    end
  end

  initial begin
    reset = 1'b1;
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #2;

    // Outputs forced low while reset is held, even with a memstall present.
    push("reset_hold", C_ZERO, 1'b0, 1'b0, 4'd0, 4'd0);

    reset = 1'b0;
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("idle", C_NORM, 1'b0, 1'b0, 4'd0, 4'd0);

    // lw x5 in EX, add uses x5 as rs2 in ID.
    set_in(5'd3, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    push("loaduse", C_LU, 1'b0, 1'b0, 4'd1, 4'd0);
    set_in(5'd3, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("loaduse_resume", C_NORM, 1'b0, 1'b0, 4'd1, 4'd0);

    // Load to x0 followed by a read of x0: no hazard.
    set_in(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    push("load_x0", C_NORM, 1'b0, 1'b0, 4'd1, 4'd0);

    // rs1 matches but is not actually read.
    set_in(5'd7, 1'b0, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    push("rs1_unused", C_NORM, 1'b0, 1'b0, 4'd1, 4'd0);

    // Three-cycle memory wait, release on the fourth.
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    push("memwait1", C_MEM, 1'b1, 1'b0, 4'd2, 4'd0);
    push("memwait2", C_MEM, 1'b1, 1'b0, 4'd3, 4'd0);
    push("memwait3", C_MEM, 1'b1, 1'b0, 4'd4, 4'd0);
    hz.mem_ready = 1'b1;
    push("memwait_release", C_NORM, 1'b0, 1'b0, 4'd4, 4'd0);

    // Redirect together with a load-use hazard: redirect wins.
    set_in(5'd1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    push("redir_loaduse", C_REDIR, 1'b0, 1'b0, 4'd4, 4'd1);

    // Redirect held off during a memory wait, taken on the release cycle.
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    push("redir_in_wait", C_MEM, 1'b1, 1'b0, 4'd5, 4'd1);
    hz.mem_ready = 1'b1;
    push("redir_on_release", C_REDIR, 1'b0, 1'b0, 4'd5, 4'd2);
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("after_redir", C_NORM, 1'b0, 1'b0, 4'd5, 4'd2);

    // Timeout: flag rises on the 4th edge spent in MEM_WAIT and sticks.
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    push("tmo1", C_MEM, 1'b1, 1'b0, 4'd6, 4'd2);
    push("tmo2", C_MEM, 1'b1, 1'b0, 4'd7, 4'd2);
    push("tmo3", C_MEM, 1'b1, 1'b0, 4'd8, 4'd2);
    push("tmo4", C_MEM, 1'b1, 1'b0, 4'd9, 4'd2);
    push("tmo5", C_MEM, 1'b1, 1'b1, 4'd10, 4'd2);
    push("tmo6", C_MEM, 1'b1, 1'b1, 4'd11, 4'd2);

    // Asynchronous reset mid-wait, away from any clock edge.
    reset = 1'b1;
    #1;
    chk("async_rst.state", 32'(hz.state), 32'd0);
    chk("async_rst.timeout", 32'(hz.mem_timeout), 32'd0);
    chk("async_rst.stall_count", 32'(hz.stall_count), 32'd0);
    chk("async_rst.flush_count", 32'(hz.flush_count), 32'd0);
    chk("async_rst.ctrl", 32'(ctrl_obs()), 32'(C_ZERO));
    push("async_rst_hold", C_ZERO, 1'b0, 1'b0, 4'd0, 4'd0);

    // Long wait from RUN: stall_count saturates at 15, timeout re-arms.
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      push($sformatf("sat%0d", k), C_MEM, 1'b1, (k >= 5),
           (k > 15) ? 4'd15 : 4'(k), 4'd0);
    end
    hz.mem_ready = 1'b1;
    push("sat_release", C_NORM, 1'b0, 1'b1, 4'd15, 4'd0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
